// File: rtl/mem_wb_stage_if.sv
// Memory-to-writeback bundle: memory-stage result in, register file write port,
// forwarding tap and retired-instruction count out.
interface mem_wb_stage_if #(
   parameter int COUNT_W = 32
);
   logic               in_valid;
   logic               stall;
   logic               flush;
   logic [4:0]         in_rd;
   logic               in_regwrite;
   logic               in_memtoreg;
   logic [31:0]        in_alu_result;
   logic [31:0]        in_mem_rdata;
   logic [1:0]         in_load_size;
   logic               in_load_unsigned;
   logic               wb_wen;
   logic [4:0]         wb_wreg;
   logic [31:0]        wb_wdata;
   logic               fwd_valid;
   logic [COUNT_W-1:0] instret;

   // The memory stage / pipeline control side drives the inputs.
   modport master (
      output in_valid, stall, flush, in_rd, in_regwrite, in_memtoreg,
             in_alu_result, in_mem_rdata, in_load_size, in_load_unsigned,
      input  wb_wen, wb_wreg, wb_wdata, fwd_valid, instret
   );

   modport slave (
      input  in_valid, stall, flush, in_rd, in_regwrite, in_memtoreg,
             in_alu_result, in_mem_rdata, in_load_size, in_load_unsigned,
      output wb_wen, wb_wreg, wb_wdata, fwd_valid, instret
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, load formatter and retired-instruction counter.
// Define MEM_WB_SUBWORD_LOAD_EN to enable byte/halfword extraction with extension.
module mem_wb_stage #(
   parameter int COUNT_W = 32
) (
   input logic           clk,
   input logic           reset,
   mem_wb_stage_if.slave bus
);

   logic               valid_q;
   logic               regwrite_q;
   logic [4:0]         wreg_q;
   logic [31:0]        wdata_q;
   logic [COUNT_W-1:0] instret_q;
   logic [31:0]        load_data;
   logic [31:0]        formatted;

`ifdef MEM_WB_SUBWORD_LOAD_EN
   logic [1:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign off = bus.in_alu_result[1:0];

   // Halfword selection uses only off[1]; a misaligned halfword silently reads its aligned half.
   always_comb begin
      byte_sel = bus.in_mem_rdata[7:0];
      case (off)
         2'd0: byte_sel = bus.in_mem_rdata[7:0];
         2'd1: byte_sel = bus.in_mem_rdata[15:8];
         2'd2: byte_sel = bus.in_mem_rdata[23:16];
         2'd3: byte_sel = bus.in_mem_rdata[31:24];
         default: byte_sel = bus.in_mem_rdata[7:0];
      endcase
      half_sel = off[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
      load_data = bus.in_mem_rdata;
      case (bus.in_load_size)
         2'b00: load_data = bus.in_load_unsigned ? {24'h0, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
         2'b01: load_data = bus.in_load_unsigned ? {16'h0, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
         default: load_data = bus.in_mem_rdata;
      endcase
   end
`else
   logic unused_subword;

   assign load_data      = bus.in_mem_rdata;
   assign unused_subword = &{1'b0, bus.in_load_size, bus.in_load_unsigned};
`endif

   always_comb begin
      formatted = bus.in_alu_result;
      if (bus.in_memtoreg) begin
         formatted = load_data;
      end
   end

   // The counter credits whatever sat in WB during the previous cycle, so it
   // trails the write by one cycle; bubbles only clear the valid bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         wreg_q     <= 5'd0;
         wdata_q    <= 32'h0;
         instret_q  <= '0;
      end else begin
         if (valid_q) begin
            instret_q <= instret_q + {{(COUNT_W-1){1'b0}}, 1'b1};
         end
         if (bus.flush || bus.stall) begin
            valid_q <= 1'b0;
         end else begin
            valid_q    <= bus.in_valid;
            regwrite_q <= bus.in_regwrite;
            wreg_q     <= bus.in_rd;
            wdata_q    <= formatted;
         end
      end
   end

   assign bus.wb_wen    = valid_q & regwrite_q & (wreg_q != 5'd0);
   assign bus.fwd_valid = bus.wb_wen;
   assign bus.wb_wreg   = wreg_q;
   assign bus.wb_wdata  = wdata_q;
   assign bus.instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: an instruction-level model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_mem_wb_stage;

   localparam int CW = 4;
`ifdef MEM_WB_SUBWORD_LOAD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checkCount = 0;
   int   passCount  = 0;

   mem_wb_stage_if #(.COUNT_W(CW)) bus ();

   mem_wb_stage #(.COUNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: the instruction currently sitting in writeback and the retire count.
   bit          modelReady = 0;
   bit          mInflight;
   bit          mRegwrite;
   logic [4:0]  mRd;
   logic [31:0] mData;
   int          mCount;

   function automatic logic [31:0] modelFormat(logic m2r, logic [31:0] alu, logic [31:0] rdata,
                                                logic [1:0] size, logic uns);
      int unsigned off;
      int unsigned v;
      if (!m2r) return alu;
      if (!SUB || size >= 2) return rdata;
      off = alu % 4;
      if (size == 2'd0) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end else begin
         v = (rdata >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
         if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         mInflight  = 0;
         mRegwrite  = 0;
         mRd        = 5'd0;
         mData      = 32'h0;
         mCount     = 0;
         modelReady = 1;
      end else begin
         if (mInflight) mCount = (mCount + 1) % (1 << CW);
         if (bus.flush || bus.stall) begin
            mInflight = 0;
         end else begin
            mInflight = bus.in_valid;
            mRegwrite = bus.in_regwrite;
            mRd       = bus.in_rd;
            mData     = modelFormat(bus.in_memtoreg, bus.in_alu_result, bus.in_mem_rdata,
                                    bus.in_load_size, bus.in_load_unsigned);
         end
      end
   end

   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("model wb_wen", {31'h0, bus.wb_wen}, {31'h0, mInflight && mRegwrite && mRd != 5'd0});
         checkOutput("model fwd_valid", {31'h0, bus.fwd_valid}, {31'h0, mInflight && mRegwrite && mRd != 5'd0});
         checkOutput("model wb_wreg", {27'h0, bus.wb_wreg}, {27'h0, mRd});
         checkOutput("model wb_wdata", bus.wb_wdata, mData);
         checkOutput("model instret", {{(32-CW){1'b0}}, bus.instret}, mCount);
      end
   end

   // Drives one cycle of inputs now, then returns at the negedge after the capturing edge.
   task automatic applyStimulus(input logic rst, input logic v, input logic rg, input logic m2r,
                                input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [1:0] size, input logic uns, input logic st, input logic fl);
      reset                = rst;
      bus.in_valid         = v;
      bus.in_regwrite      = rg;
      bus.in_memtoreg      = m2r;
      bus.in_rd            = rd;
      bus.in_alu_result    = alu;
      bus.in_mem_rdata     = rdata;
      bus.in_load_size     = size;
      bus.in_load_unsigned = uns;
      bus.stall            = st;
      bus.flush            = fl;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 0, 0, 0);
   endtask

   task automatic aluOp(input logic [4:0] rd, input logic [31:0] alu);
      applyStimulus(0, 1, 1, 0, rd, alu, 32'h0, 2'd0, 0, 0, 0);
   endtask

   task automatic loadOp(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [1:0] size, input logic uns);
      applyStimulus(0, 1, 1, 1, rd, alu, rdata, size, uns, 0, 0);
   endtask

   task automatic checkWrite(input string name, input logic [4:0] rd, input logic [31:0] data);
      checkOutput({name, " wen"}, {31'h0, bus.wb_wen}, 32'h1);
      checkOutput({name, " wreg"}, {27'h0, bus.wb_wreg}, {27'h0, rd});
      checkOutput({name, " wdata"}, bus.wb_wdata, data);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 5'd9, 32'hFFFF, 32'h0, 2'd0, 0, 0, 0);
      checkOutput("reset wen", {31'h0, bus.wb_wen}, 32'h0);
      checkOutput("reset wreg", {27'h0, bus.wb_wreg}, 32'h0);
      checkOutput("reset wdata", bus.wb_wdata, 32'h0);
      checkOutput("reset instret", {{(32-CW){1'b0}}, bus.instret}, 32'h0);
      idle();

      aluOp(5'd5, 32'h12345678);
      checkWrite("alu", 5'd5, 32'h12345678);
      idle();
      checkOutput("alu idle wen", {31'h0, bus.wb_wen}, 32'h0);
      checkOutput("alu instret", {{(32-CW){1'b0}}, bus.instret}, 32'd1);

      loadOp(5'd6, 32'h1002, 32'h80FF7F01, 2'd0, 0);
      checkWrite("byte signed off2", 5'd6, SUB ? 32'hFFFFFFFF : 32'h80FF7F01);
      loadOp(5'd6, 32'h1002, 32'h80FF7F01, 2'd0, 1);
      checkWrite("byte unsigned off2", 5'd6, SUB ? 32'h000000FF : 32'h80FF7F01);
      loadOp(5'd6, 32'h1003, 32'h80FF7F01, 2'd0, 0);
      checkWrite("byte signed off3", 5'd6, SUB ? 32'hFFFFFF80 : 32'h80FF7F01);
      loadOp(5'd10, 32'h2003, 32'h80017FFE, 2'd1, 0);
      checkWrite("half signed off3", 5'd10, SUB ? 32'hFFFF8001 : 32'h80017FFE);
      loadOp(5'd10, 32'h2000, 32'h80017FFE, 2'd1, 0);
      checkWrite("half signed off0", 5'd10, 32'h80017FFE ^ (SUB ? 32'h80010000 : 32'h0));
      loadOp(5'd11, 32'h2001, 32'hA5A5C3C3, 2'd2, 0);
      checkWrite("word", 5'd11, 32'hA5A5C3C3);
      loadOp(5'd11, 32'h2002, 32'h0BADF00D, 2'd3, 1);
      checkWrite("reserved size", 5'd11, 32'h0BADF00D);

      applyStimulus(0, 1, 1, 0, 5'd0, 32'h77, 32'h0, 2'd0, 0, 0, 0);
      checkOutput("r0 write wen", {31'h0, bus.wb_wen}, 32'h0);
      idle();
      checkOutput("r0 instret", {{(32-CW){1'b0}}, bus.instret}, 32'd9);

      applyStimulus(0, 1, 1, 0, 5'd7, 32'hDEADBEEF, 32'h0, 2'd0, 0, 1, 0);
      checkOutput("stall wen", {31'h0, bus.wb_wen}, 32'h0);
      checkOutput("stall wdata held", bus.wb_wdata, 32'h0);
      applyStimulus(0, 1, 1, 0, 5'd7, 32'hDEADBEEF, 32'h0, 2'd0, 0, 1, 1);
      checkOutput("stall+flush wen", {31'h0, bus.wb_wen}, 32'h0);
      applyStimulus(0, 1, 1, 0, 5'd7, 32'hDEADBEEF, 32'h0, 2'd0, 0, 0, 1);
      checkOutput("flush wen", {31'h0, bus.wb_wen}, 32'h0);
      checkOutput("bubble instret", {{(32-CW){1'b0}}, bus.instret}, 32'd9);
      aluOp(5'd7, 32'hCAFEF00D);
      checkWrite("after stall", 5'd7, 32'hCAFEF00D);

      aluOp(5'd8, 32'h55);
      checkOutput("pre-reset instret", {{(32-CW){1'b0}}, bus.instret}, 32'd10);
      applyStimulus(1, 1, 1, 0, 5'd9, 32'h66, 32'h0, 2'd0, 0, 0, 0);
      checkOutput("mid reset wen", {31'h0, bus.wb_wen}, 32'h0);
      checkOutput("mid reset wdata", bus.wb_wdata, 32'h0);
      checkOutput("mid reset instret", {{(32-CW){1'b0}}, bus.instret}, 32'h0);
      idle();
      checkOutput("post reset wen", {31'h0, bus.wb_wen}, 32'h0);

      for (int i = 0; i < 16; i++) aluOp(5'd1, i);
      checkOutput("wrap pre instret", {{(32-CW){1'b0}}, bus.instret}, 32'd15);
      idle();
      checkOutput("wrap instret", {{(32-CW){1'b0}}, bus.instret}, 32'd0);
      idle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
